// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the ICACHE/DCACHE memory arbiter: FSM state encoding,
// grant identifiers and the tie-break helper used when both caches request.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2
    } arb_state_e;

    typedef logic grant_t;

    localparam grant_t GNT_I = 1'b0;
    localparam grant_t GNT_D = 1'b1;

    // On a tie the client that was not granted last wins; otherwise the sole requester.
    function automatic grant_t pick_winner(input logic i_req, input logic d_req, input grant_t last);
        grant_t w;
        if (i_req && d_req) begin
            w = (last == GNT_I) ? GNT_D : GNT_I;
        end else if (d_req) begin
            w = GNT_D;
        end else begin
            w = GNT_I;
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block memory port between ICACHE (read-only)
// and DCACHE (read/write). Memory command outputs are driven straight from flops.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              I_mem_read,
    input  logic [ADDR_W-1:0] I_mem_addr,
    output logic [DATA_W-1:0] I_mem_rdata,
    output logic              I_mem_ready,

    input  logic              D_mem_read,
    input  logic              D_mem_write,
    input  logic [ADDR_W-1:0] D_mem_addr,
    input  logic [DATA_W-1:0] D_mem_wdata,
    output logic [DATA_W-1:0] D_mem_rdata,
    output logic              D_mem_ready,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_e        state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;

    logic              i_req;
    logic              d_req;
    grant_t            winner;

    assign i_req = I_mem_read;
    assign d_req = D_mem_read | D_mem_write;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        winner       = pick_winner(i_req, d_req, last_grant_q);

        unique case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    if (winner == GNT_D) begin
                        state_d     = ST_SERVE_D;
                        addr_d      = D_mem_addr;
                        wdata_d     = D_mem_wdata;
                        // A simultaneous read+write is carried out as a write.
                        mem_write_d = D_mem_write;
                        mem_read_d  = ~D_mem_write;
                    end else begin
                        state_d     = ST_SERVE_I;
                        addr_d      = I_mem_addr;
                        mem_read_d  = 1'b1;
                        mem_write_d = 1'b0;
                    end
                end
            end
            ST_SERVE_I: begin
                if (mem_ready) begin
                    state_d      = ST_IDLE;
                    mem_read_d   = 1'b0;
                    mem_write_d  = 1'b0;
                    last_grant_d = GNT_I;
                end
            end
            ST_SERVE_D: begin
                if (mem_ready) begin
                    state_d      = ST_IDLE;
                    mem_read_d   = 1'b0;
                    mem_write_d  = 1'b0;
                    last_grant_d = GNT_D;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_I;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
        end
    end

    // Completion is signalled in the same cycle the memory reports ready.
    assign I_mem_ready = (state_q == ST_SERVE_I) && mem_ready;
    assign D_mem_ready = (state_q == ST_SERVE_D) && mem_ready;
    assign I_mem_rdata = mem_rdata;
    assign D_mem_rdata = mem_rdata;

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected transfers are queued when requests are
// raised and checked against the memory port and client ready/rdata as they complete.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          I_mem_read = 1'b0;
    logic [AW-1:0] I_mem_addr = '0;
    logic [DW-1:0] I_mem_rdata;
    logic          I_mem_ready;
    logic          D_mem_read = 1'b0;
    logic          D_mem_write = 1'b0;
    logic [AW-1:0] D_mem_addr = '0;
    logic [DW-1:0] D_mem_wdata = '0;
    logic [DW-1:0] D_mem_rdata;
    logic          D_mem_ready;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .I_mem_read  (I_mem_read),
        .I_mem_addr  (I_mem_addr),
        .I_mem_rdata (I_mem_rdata),
        .I_mem_ready (I_mem_ready),
        .D_mem_read  (D_mem_read),
        .D_mem_write (D_mem_write),
        .D_mem_addr  (D_mem_addr),
        .D_mem_wdata (D_mem_wdata),
        .D_mem_rdata (D_mem_rdata),
        .D_mem_ready (D_mem_ready),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          is_d;
        logic          is_write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  grant_cyc = 0;
    int  ready_cyc = 0;

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return {4{32'hC0DE_0000 ^ {4'h0, a}}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic is_d, input logic is_write, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd);
        sb_t e;
        e.is_d = is_d;
        e.is_write = is_write;
        e.addr = a;
        e.wdata = wd;
        sb.push_back(e);
    endtask

    task automatic apply_drop(input logic [1:0] mask);
        if (mask[1]) begin
            D_mem_read  = 1'b0;
            D_mem_write = 1'b0;
        end
        if (mask[0]) I_mem_read = 1'b0;
    endtask

    // Memory responder: waits for a command, checks it stays stable for lat cycles,
    // returns ready, and checks the completion against the scoreboard head.
    task automatic mem_respond(input int lat, input logic [1:0] drop_early, input logic [1:0] drop_after);
        sb_t exp;
        int  n;
        logic [DW-1:0] rd;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_empty: no expected transfer queued");
            return;
        end
        exp = sb[0];
        n = 0;
        @(negedge clk);
        while (!(mem_read || mem_write) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL grant_timeout: no memory command within 20 cycles for addr %0h", exp.addr);
            void'(sb.pop_front());
            return;
        end
        grant_cyc = cyc;
        for (int i = 0; i < lat; i++) begin
            checks++;
            if (mem_addr !== exp.addr || mem_read !== !exp.is_write || mem_write !== exp.is_write) begin
                errors++;
                $display("FAIL cmd_hold: got addr %0h rd %0b wr %0b want addr %0h rd %0b wr %0b",
                         mem_addr, mem_read, mem_write, exp.addr, !exp.is_write, exp.is_write);
            end
            if (exp.is_write) begin
                checks++;
                if (mem_wdata !== exp.wdata) begin
                    errors++;
                    $display("FAIL wdata_hold: got %0h want %0h", mem_wdata, exp.wdata);
                end
            end
            checks++;
            if (I_mem_ready !== 1'b0 || D_mem_ready !== 1'b0) begin
                errors++;
                $display("FAIL early_ready: got I %0b D %0b want 0 0", I_mem_ready, D_mem_ready);
            end
            tick();
            if (i == 0) apply_drop(drop_early);
        end
        rd = mem_data(exp.addr);
        mem_ready = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        ready_cyc = cyc;
        checks++;
        if (I_mem_ready !== !exp.is_d || D_mem_ready !== exp.is_d) begin
            errors++;
            $display("FAIL ready_pulse: got I %0b D %0b want I %0b D %0b",
                     I_mem_ready, D_mem_ready, !exp.is_d, exp.is_d);
        end
        checks++;
        if ((exp.is_d ? D_mem_rdata : I_mem_rdata) !== rd) begin
            errors++;
            $display("FAIL rdata: got %0h want %0h", exp.is_d ? D_mem_rdata : I_mem_rdata, rd);
        end
        checks++;
        if (mem_read !== !exp.is_write || mem_write !== exp.is_write) begin
            errors++;
            $display("FAIL cmd_at_ready: got rd %0b wr %0b want rd %0b wr %0b",
                     mem_read, mem_write, !exp.is_write, exp.is_write);
        end
        tick();
        mem_ready = 1'b0;
        apply_drop(drop_after);
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || I_mem_ready !== 1'b0 || D_mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_gap: got rd %0b wr %0b rdyI %0b rdyD %0b want 0 0 0 0",
                     mem_read, mem_write, I_mem_ready, D_mem_ready);
        end
        $display("xfer %s %s addr %0h done cycle %0d", exp.is_d ? "D" : "I",
                 exp.is_write ? "WR" : "RD", exp.addr, ready_cyc);
        void'(sb.pop_front());
    endtask

    task automatic do_reset();
        I_mem_read = 1'b0;
        D_mem_read = 1'b0;
        D_mem_write = 1'b0;
        mem_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rd %0b wr %0b addr %0h wdata %0h want all 0",
                     mem_read, mem_write, mem_addr, mem_wdata);
        end
        checks++;
        if (I_mem_ready !== 1'b0 || D_mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got I %0b D %0b want 0 0", I_mem_ready, D_mem_ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: got rd %0b wr %0b want 0 0", mem_read, mem_write);
        end
        $display("reset test done");
    endtask

    task automatic test_single_i();
        int c0;
        tick();
        c0 = cyc;
        I_mem_addr = 28'h000_0010;
        I_mem_read = 1'b1;
        push_exp(1'b0, 1'b0, I_mem_addr, '0);
        mem_respond(3, 2'b00, 2'b01);
        checks++;
        if (grant_cyc - c0 !== 1) begin
            errors++;
            $display("FAIL grant_latency: got %0d want 1", grant_cyc - c0);
        end
        checks++;
        if (ready_cyc - c0 !== 4) begin
            errors++;
            $display("FAIL ready_latency: got %0d want 4", ready_cyc - c0);
        end
    endtask

    task automatic test_tie();
        int d_done;
        do_reset();
        I_mem_addr = 28'h000_0040;
        D_mem_addr = 28'h000_0050;
        I_mem_read = 1'b1;
        D_mem_read = 1'b1;
        push_exp(1'b1, 1'b0, 28'h000_0050, '0);
        push_exp(1'b0, 1'b0, 28'h000_0040, '0);
        mem_respond(2, 2'b00, 2'b10);
        d_done = ready_cyc;
        mem_respond(2, 2'b00, 2'b01);
        checks++;
        if (grant_cyc - d_done !== 2) begin
            errors++;
            $display("FAIL b2b_gap: got %0d cycles want 2", grant_cyc - d_done);
        end
    endtask

    task automatic test_d_write();
        tick();
        D_mem_addr  = 28'h000_0020;
        D_mem_wdata = {16{8'hA5}};
        D_mem_write = 1'b1;
        push_exp(1'b1, 1'b1, D_mem_addr, D_mem_wdata);
        mem_respond(4, 2'b00, 2'b10);
        D_mem_addr  = 28'h000_0024;
        D_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
        D_mem_read  = 1'b1;
        D_mem_write = 1'b1;
        push_exp(1'b1, 1'b1, D_mem_addr, D_mem_wdata);
        mem_respond(1, 2'b00, 2'b10);
    endtask

    task automatic test_alternate();
        do_reset();
        I_mem_addr = 28'h000_0100;
        D_mem_addr = 28'h000_0200;
        I_mem_read = 1'b1;
        D_mem_read = 1'b1;
        push_exp(1'b1, 1'b0, 28'h000_0200, '0);
        push_exp(1'b0, 1'b0, 28'h000_0100, '0);
        push_exp(1'b1, 1'b0, 28'h000_0200, '0);
        push_exp(1'b0, 1'b0, 28'h000_0100, '0);
        mem_respond(1, 2'b00, 2'b00);
        mem_respond(2, 2'b00, 2'b00);
        mem_respond(1, 2'b00, 2'b00);
        mem_respond(1, 2'b00, 2'b11);
    endtask

    task automatic test_drop_midflight();
        tick();
        I_mem_addr = 28'h000_0300;
        I_mem_read = 1'b1;
        push_exp(1'b0, 1'b0, I_mem_addr, '0);
        mem_respond(3, 2'b01, 2'b01);
    endtask

    task automatic test_reset_mid();
        int n;
        tick();
        D_mem_addr  = 28'h000_0400;
        D_mem_wdata = {4{32'h1234_5678}};
        D_mem_write = 1'b1;
        n = 0;
        @(negedge clk);
        while (mem_write !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL rst_mid_grant: got no mem_write want 1 within 20 cycles");
        end
        tick();
        rst_n = 1'b0;
        #1;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL rst_mid_cmd: got wr %0b addr %0h wdata %0h want 0 0 0", mem_write, mem_addr, mem_wdata);
        end
        checks++;
        if (D_mem_ready !== 1'b0 || I_mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_ready: got D %0b I %0b want 0 0", D_mem_ready, I_mem_ready);
        end
        D_mem_write = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (D_mem_ready !== 1'b0 || mem_write !== 1'b0 || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_after: got rdyD %0b wr %0b rd %0b want 0 0 0", D_mem_ready, mem_write, mem_read);
        end
        mem_ready = 1'b0;
        $display("reset mid-transfer test done");
    endtask

    task automatic test_ready_idle();
        tick();
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            checks++;
            if (I_mem_ready !== 1'b0 || D_mem_ready !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
                errors++;
                $display("FAIL idle_ready: got rdyI %0b rdyD %0b rd %0b wr %0b want 0 0 0 0",
                         I_mem_ready, D_mem_ready, mem_read, mem_write);
            end
            checks++;
            if (I_mem_rdata !== mem_rdata || D_mem_rdata !== mem_rdata) begin
                errors++;
                $display("FAIL rdata_mirror: got I %0h D %0h want %0h", I_mem_rdata, D_mem_rdata, mem_rdata);
            end
            tick();
        end
        mem_ready = 1'b0;
        I_mem_addr = 28'h000_0500;
        I_mem_read = 1'b1;
        push_exp(1'b0, 1'b0, I_mem_addr, '0);
        mem_respond(1, 2'b00, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_i();
        test_tie();
        test_d_write();
        test_alternate();
        test_drop_midflight();
        test_reset_mid();
        test_ready_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, meaning memory block address width.
REQ-002 SHALL have parameter DATA_W, default 128, meaning memory block data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port I_mem_read  input  1  ICACHE block-read request, held until I_mem_ready.
REQ-006 SHALL have port I_mem_addr  input  ADDR_W  ICACHE block address.
REQ-007 SHALL have port I_mem_rdata  output  DATA_W  block returned to ICACHE.
REQ-008 SHALL have port I_mem_ready  output  1  ICACHE transfer complete, one-cycle pulse.
REQ-009 SHALL have port D_mem_read  input  1  DCACHE block-read request, held until D_mem_ready.
REQ-010 SHALL have port D_mem_write  input  1  DCACHE block-write request, held until D_mem_ready.
REQ-011 SHALL have port D_mem_addr  input  ADDR_W  DCACHE block address.
REQ-012 SHALL have port D_mem_wdata  input  DATA_W  DCACHE write block.
REQ-013 SHALL have port D_mem_rdata  output  DATA_W  block returned to DCACHE.
REQ-014 SHALL have port D_mem_ready  output  1  DCACHE transfer complete, one-cycle pulse.
REQ-015 SHALL have ports mem_read, mem_write  output  1 each  shared memory command.
REQ-016 SHALL have ports mem_addr  output  ADDR_W, mem_wdata  output  DATA_W  shared memory address/data.
REQ-017 SHALL have ports mem_rdata  input  DATA_W, mem_ready  input  1  memory response.

Function
REQ-018 SHALL implement FSM states IDLE, SERVE_I, SERVE_D.
REQ-019 IDLE, no request pending: SHALL stay IDLE, mem_read=mem_write=0.
REQ-020 IDLE, only I request pending: SHALL go SERVE_I; only D (read or write) pending: SHALL go SERVE_D.
REQ-021 IDLE, both pending: SHALL grant the client not granted last (round-robin via 1-bit last_grant register; last_grant resets to I, so D wins first tie).
REQ-022 On grant, SHALL latch client address (and D wdata, read/write kind) into registers; mem_* SHALL be driven only from these registers (registered outputs, one-cycle grant latency).
REQ-023 In SERVE_x, SHALL hold mem_read/mem_write/mem_addr/mem_wdata constant until mem_ready=1.
REQ-024 On mem_ready=1 in SERVE_x: SHALL assert x_mem_ready combinationally that cycle, drive x_mem_rdata=mem_rdata, deassert mem_read/mem_write next cycle, update last_grant=x, return to IDLE.
REQ-025 Ungranted client's ready SHALL remain 0; its request SHALL stay pending untouched.
REQ-026 I_mem_rdata and D_mem_rdata SHALL both mirror mem_rdata at all times (qualified by ready only).
REQ-027 D_mem_read and D_mem_write both high SHALL be treated as write (write takes precedence).
REQ-028 mem_ready while IDLE SHALL be ignored (no client ready, no state change).
REQ-029 Requests dropped before ready (protocol violation) SHALL NOT abort an in-flight transfer.
REQ-030 Back-to-back: minimum one IDLE cycle between completion and next grant.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, last_grant=I, latched addr/wdata=0, mem_read=mem_write=0, mem_addr=0, mem_wdata=0.
REQ-032 Reset mid-transfer SHALL abandon the transfer with no ready pulse to either client.

Structure
REQ-033 FSM state encoding and grant-id constants (GNT_I, GNT_D) SHALL live in a shared package.
REQ-034 SHALL be one flat module; no sub-module.
REQ-035 Combinational next-state/next-output block separated from one sequential register block.

Verification
REQ-036 I read addr 0x0000010 alone, memory ready after 3 cycles -> mem_read=1 from cycle 1, I_mem_ready pulse cycle 4, I_mem_rdata=mem_rdata.
REQ-037 I and D read both assert same cycle after reset -> D served first, then I after one IDLE cycle.
REQ-038 D write addr 0x0000020 wdata 0xA5..A5 -> mem_write=1, mem_addr/mem_wdata stable until mem_ready, D_mem_ready one pulse.
REQ-039 I and D continuously requesting -> grants alternate D,I,D,I over 4 transfers.
REQ-040 rst_n low while SERVE_D with mem_ready pending -> mem_write=0 immediately, no D_mem_ready, state IDLE.
REQ-041 mem_ready=1 while IDLE -> neither client ready asserted.
